// File: rtl/dram_pkg.sv
// Shared types and default 7.09 MHz timing for the FastRAM refresh scheduler.
package dram_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ACCESS,
    CAS,
    RAS,
    PRE
  } state_t;

  localparam int REFRESH_INTERVAL_7M = 108;  // 4096 rows in 64 ms at 7.09 MHz
  localparam int MAX_PENDING_DEF     = 8;
  localparam int TCSR_CYC            = 1;
  localparam int TRAS_CYC            = 2;
  localparam int TRP_CYC             = 1;
  localparam int PENDING_W           = 4;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/refresh_backlog_counter.sv
// Fixed-interval refresh timer feeding a saturating backlog of owed refreshes.
module refresh_backlog_counter
  import dram_pkg::*;
#(
  parameter int INTERVAL    = REFRESH_INTERVAL_7M,
  parameter int MAX_PENDING = MAX_PENDING_DEF
) (
  input  logic                 CLK,
  input  logic                 RESETn,
  input  logic                 done,
  output logic                 tick,
  output logic [PENDING_W-1:0] pending,
  output logic                 overflow
);

  localparam int TIMER_W = $clog2(INTERVAL);

  logic [TIMER_W-1:0] timer;

  assign tick = (timer == TIMER_W'(INTERVAL - 1));

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      timer    <= '0;
      pending  <= '0;
      overflow <= 1'b0;
    end else begin
      timer <= tick ? '0 : timer + TIMER_W'(1);
      // A tick and a completed refresh in the same cycle cancel out.
      unique case ({tick, done})
        2'b10: begin
          if (pending == PENDING_W'(MAX_PENDING)) overflow <= 1'b1;
          else                                    pending  <= pending + PENDING_W'(1);
        end
        2'b01: begin
          if (pending != '0) pending <= pending - PENDING_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/dram_refresh_scheduler.sv
// Arbitrates the FastRAM array between CPU access cycles and CAS-before-RAS refresh.
module dram_refresh_scheduler
  import dram_pkg::*;
#(
  parameter int INTERVAL    = REFRESH_INTERVAL_7M,
  parameter int MAX_PENDING = MAX_PENDING_DEF,
  parameter int CAS_CYCLES  = TCSR_CYC,
  parameter int RAS_CYCLES  = TRAS_CYC,
  parameter int PRE_CYCLES  = TRP_CYC
) (
  input  logic                 CLK,
  input  logic                 RESETn,
  input  logic                 access_req,
  output logic                 access_grant,
  output logic                 refresh_cas,
  output logic                 refresh_ras,
  output logic                 busy,
  output logic [PENDING_W-1:0] pending,
  output logic                 overflow
);

  localparam int PHASE_W = $clog2(max3(CAS_CYCLES, RAS_CYCLES, PRE_CYCLES) + 1);

  state_t             state;
  logic [PHASE_W-1:0] phase;
  logic               tick;
  logic               done;
  logic               urgent;
  logic               phase_last;

  assign phase_last = (phase == PHASE_W'(1));
  assign done       = (state == RAS) && phase_last;
  assign urgent     = (pending == PENDING_W'(MAX_PENDING));
  assign busy       = (state != IDLE);

  refresh_backlog_counter #(
    .INTERVAL    (INTERVAL),
    .MAX_PENDING (MAX_PENDING)
  ) u_backlog (
    .CLK      (CLK),
    .RESETn   (RESETn),
    .done     (done),
    .tick     (tick),
    .pending  (pending),
    .overflow (overflow)
  );

  // Grant is combinational so the bus cycle starts in the same cycle it is seen in IDLE.
  assign access_grant = access_req && ((state == ACCESS) || ((state == IDLE) && !urgent));

  // Strobes are registered alongside the state so they change cleanly on the edge.
  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      state       <= IDLE;
      phase       <= '0;
      refresh_cas <= 1'b0;
      refresh_ras <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (access_req && !urgent) begin
            state <= ACCESS;
          end else if (pending != '0) begin
            state       <= CAS;
            phase       <= PHASE_W'(CAS_CYCLES);
            refresh_cas <= 1'b1;
          end
        end
        ACCESS: begin
          if (!access_req) begin
            state <= PRE;
            phase <= PHASE_W'(PRE_CYCLES);
          end
        end
        CAS: begin
          if (phase_last) begin
            state       <= RAS;
            phase       <= PHASE_W'(RAS_CYCLES);
            refresh_ras <= 1'b1;
          end else begin
            phase <= phase - PHASE_W'(1);
          end
        end
        RAS: begin
          if (phase_last) begin
            state       <= PRE;
            phase       <= PHASE_W'(PRE_CYCLES);
            refresh_cas <= 1'b0;
            refresh_ras <= 1'b0;
          end else begin
            phase <= phase - PHASE_W'(1);
          end
        end
        PRE: begin
          if (phase_last) state <= IDLE;
          else            phase <= phase - PHASE_W'(1);
        end
        default: begin
          state       <= IDLE;
          refresh_cas <= 1'b0;
          refresh_ras <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dram_refresh_scheduler.sv
// Directed bench for dram_refresh_scheduler; edge counts are relative to reset release.
module tb_dram_refresh_scheduler;
  import dram_pkg::*;

  logic                 CLK;
  logic                 RESETn;
  logic                 access_req;
  logic                 access_grant;
  logic                 refresh_cas;
  logic                 refresh_ras;
  logic                 busy;
  logic [PENDING_W-1:0] pending;
  logic                 overflow;

  int vectors;
  int miscompares;
  int edge_cnt;

  dram_refresh_scheduler dut (
    .CLK          (CLK),
    .RESETn       (RESETn),
    .access_req   (access_req),
    .access_grant (access_grant),
    .refresh_cas  (refresh_cas),
    .refresh_ras  (refresh_ras),
    .busy         (busy),
    .pending      (pending),
    .overflow     (overflow)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s @edge %0d: observed %0d expected %0d", tag, edge_cnt, obs, exp);
    end
  endtask

  // Advance to just after rising edge n (counted from reset release).
  task automatic adv_to(input int n);
    while (edge_cnt < n) begin
      @(posedge CLK);
      edge_cnt++;
    end
    #1;
  endtask

  task automatic do_reset();
    RESETn = 1'b0;
    @(posedge CLK);
    #1;
    RESETn   = 1'b1;
    edge_cnt = 0;
  endtask

  // Refresh strobes must never overlap a grant.
  always @(negedge CLK) begin
    if (RESETn) begin
      vectors++;
      assert (!(access_grant && (refresh_cas || refresh_ras)))
      else begin
        miscompares++;
        $error("FAIL excl: grant=%0b cas=%0b ras=%0b expected no overlap",
               access_grant, refresh_cas, refresh_ras);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vectors     = 0;
    miscompares = 0;
    edge_cnt    = 0;
    RESETn      = 1'b0;
    access_req  = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    check("rst_cas",   8'(refresh_cas),  8'd0);
    check("rst_ras",   8'(refresh_ras),  8'd0);
    check("rst_busy",  8'(busy),         8'd0);
    check("rst_pend",  8'(pending),      8'd0);
    check("rst_ovf",   8'(overflow),     8'd0);
    check("rst_grant", 8'(access_grant), 8'd0);
    RESETn   = 1'b1;
    edge_cnt = 0;

    // Idle bus: refresh one cycle after each tick.
    adv_to(107); check("idle_pend107", 8'(pending), 8'd0);
    adv_to(108); check("idle_pend108", 8'(pending), 8'd1);
                 check("idle_cas108",  8'(refresh_cas), 8'd0);
    adv_to(109); check("idle_cas109",  8'(refresh_cas), 8'd1);
                 check("idle_ras109",  8'(refresh_ras), 8'd0);
    adv_to(110); check("idle_ras110",  8'(refresh_ras), 8'd1);
    adv_to(111); check("idle_ras111",  8'(refresh_ras), 8'd1);
                 check("idle_cas111",  8'(refresh_cas), 8'd1);
    adv_to(112); check("idle_ras112",  8'(refresh_ras), 8'd0);
                 check("idle_pend112", 8'(pending), 8'd0);
                 check("idle_busy112", 8'(busy), 8'd1);
    adv_to(113); check("idle_busy113", 8'(busy), 8'd0);
    adv_to(216); check("idle_cas216",  8'(refresh_cas), 8'd0);
    adv_to(217); check("idle_cas217",  8'(refresh_cas), 8'd1);
    adv_to(433); check("idle_cas433",  8'(refresh_cas), 8'd1);

    // Access held from reset: backlog builds, then saturates and overflows.
    access_req = 1'b1;
    do_reset();
    check("acc_grant0",  8'(access_grant), 8'd1);
    adv_to(863); check("acc_pend863", 8'(pending), 8'd7);
    adv_to(864); check("acc_pend864", 8'(pending), 8'd8);
                 check("acc_grant864", 8'(access_grant), 8'd1);
    adv_to(971); check("acc_ovf971",  8'(overflow), 8'd0);
    adv_to(972); check("acc_ovf972",  8'(overflow), 8'd1);
                 check("acc_pend972", 8'(pending), 8'd8);
    adv_to(1000); check("acc_grant1000", 8'(access_grant), 8'd1);
    access_req = 1'b0;
    #1;
    check("drain_grant_off", 8'(access_grant), 8'd0);
    adv_to(1001); check("drain_busy1001", 8'(busy), 8'd1);
    adv_to(1002); check("drain_busy1002", 8'(busy), 8'd0);
    adv_to(1003); check("drain_cas1003",  8'(refresh_cas), 8'd1);
    adv_to(1006); check("drain_pend1006", 8'(pending), 8'd7);
    adv_to(1040); check("drain_pend1040", 8'(pending), 8'd1);
    adv_to(1041); check("drain_pend1041", 8'(pending), 8'd0);
    adv_to(1042); check("drain_busy1042", 8'(busy), 8'd0);
                  check("drain_ovf1042",  8'(overflow), 8'd1);

    // Urgent backlog: request seen in IDLE waits for one refresh.
    access_req = 1'b1;
    do_reset();
    adv_to(900); access_req = 1'b0;
    adv_to(901); access_req = 1'b1;
    #1;
    check("urg_grant_pre", 8'(access_grant), 8'd0);
    adv_to(902); check("urg_grant902", 8'(access_grant), 8'd0);
                 check("urg_pend902",  8'(pending), 8'd8);
    adv_to(903); check("urg_cas903",   8'(refresh_cas), 8'd1);
                 check("urg_grant903", 8'(access_grant), 8'd0);
    adv_to(904); check("urg_ras904",   8'(refresh_ras), 8'd1);
    adv_to(906); check("urg_grant906", 8'(access_grant), 8'd0);
                 check("urg_pend906",  8'(pending), 8'd7);
    adv_to(907); check("urg_grant907", 8'(access_grant), 8'd1);
    adv_to(908); check("urg_busy908",  8'(busy), 8'd1);
                 check("urg_grant908", 8'(access_grant), 8'd1);
    access_req = 1'b0;

    // Tick coincides with a refresh completing at pending 3.
    access_req = 1'b1;
    do_reset();
    adv_to(432); check("coin_pend432", 8'(pending), 8'd4);
    adv_to(529); access_req = 1'b0;
    adv_to(535); check("coin_pend535", 8'(pending), 8'd3);
    adv_to(539); check("coin_pend539", 8'(pending), 8'd3);
                 check("coin_ras539",  8'(refresh_ras), 8'd1);
    adv_to(540); check("coin_pend540", 8'(pending), 8'd3);
                 check("coin_ras540",  8'(refresh_ras), 8'd0);
    adv_to(542); check("coin_cas542",  8'(refresh_cas), 8'd1);
    adv_to(543); check("coin_ras543",  8'(refresh_ras), 8'd1);

    // Reset mid-RAS aborts the refresh and restarts the timer.
    RESETn = 1'b0;
    @(posedge CLK);
    #1;
    check("mid_cas",  8'(refresh_cas), 8'd0);
    check("mid_ras",  8'(refresh_ras), 8'd0);
    check("mid_busy", 8'(busy),        8'd0);
    check("mid_pend", 8'(pending),     8'd0);
    RESETn   = 1'b1;
    edge_cnt = 0;
    adv_to(107); check("mid_pend107", 8'(pending), 8'd0);
    adv_to(108); check("mid_pend108", 8'(pending), 8'd1);
    adv_to(109); check("mid_cas109",  8'(refresh_cas), 8'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dram_refresh_scheduler.md
Name: dram_refresh_scheduler

Overview:
- Schedules CAS-before-RAS refresh for the Zorro II FastRAM DRAM array.
- Arbitrates the array between CPU access cycles and refresh.
- Uses a fixed-interval refresh timer with a deferred-refresh backlog, so refreshes queue while the CPU is busy and drain when the bus is idle.
- Drives refresh CAS/RAS strobes and an access grant to the RAM access sequencer. Sits between the bus interface (address match / AS qualification) and the RAS/CAS output drivers.

Parameters:
- INTERVAL, 108, CLK cycles between refresh ticks (≈15.2 µs at 7.09 MHz; 4096 rows in 64 ms).
- MAX_PENDING, 8, backlog depth; at this count refresh becomes urgent.
- CAS_CYCLES, 1, CLK cycles CAS is held alone before RAS (tCSR).
- RAS_CYCLES, 2, CLK cycles RAS and CAS are held together.
- PRE_CYCLES, 1, precharge CLK cycles after any refresh or access before the next operation.

Ports:
- CLK  in  1  7 MHz system clock; all logic is on the rising edge.
- RESETn  in  1  reset, synchronous, active-low.
- access_req  in  1  qualified RAM cycle request (address matched and AS asserted). Held until the bus cycle ends.
- access_grant  out  1  array granted to the access sequencer for the current bus cycle.
- refresh_cas  out  1  assert refresh CAS, both banks and both bytes.
- refresh_ras  out  1  assert refresh RAS on all four RAS lines.
- busy  out  1  state is not IDLE.
- pending  out  4  current refresh backlog, 0..MAX_PENDING.
- overflow  out  1  sticky flag: a tick was lost at saturation.

Behaviour:
- Reset (RESETn low at a CLK edge):
  - state=IDLE; timer=0; pending=0; all outputs 0; overflow cleared.
  - Reset during any state aborts that state immediately, with no precharge.
- Timer:
  - Counts 0..INTERVAL-1 and wraps to 0.
  - tick=1 for the one cycle in which timer==INTERVAL-1.
- Backlog: next pending = pending + tick − done, where done is a 1-cycle pulse on the RAS→PRE transition.
  - tick and done in the same cycle: pending unchanged.
  - tick at pending==MAX_PENDING with no done: pending stays MAX_PENDING and overflow←1.
  - pending never decrements below 0.
- urgent = (pending==MAX_PENDING).
- FSM states: IDLE, ACCESS, CAS, RAS, PRE.
  - IDLE:
    - access_req && !urgent → ACCESS. access_grant=1 in the same cycle (combinational from state and inputs).
    - else pending>0 → CAS.
    - else stay in IDLE.
    - access_req and pending>0 together, not urgent: access wins.
  - ACCESS: access_grant=1 while access_req=1. When access_req falls → PRE.
  - CAS: refresh_cas=1 for CAS_CYCLES cycles → RAS. A new access_req waits with no grant.
  - RAS: refresh_cas=1 and refresh_ras=1 for RAS_CYCLES cycles → PRE; done pulses on this exit.
  - PRE: all strobes 0 for PRE_CYCLES cycles → IDLE. An arriving access_req is only granted from IDLE.
- Refresh is never preempted once CAS is entered; an access is never preempted once granted.
- Urgent with access_req held: access is refused in IDLE and one refresh runs. After PRE, urgent is false again (pending = MAX−1), so the access is granted.
- Worst-case grant latency from IDLE with urgent set: CAS_CYCLES+RAS_CYCLES+PRE_CYCLES = 4 cycles.
- refresh_cas, refresh_ras and access_grant are mutually exclusive with respect to access_grant; the checker asserts this every cycle.
- Phase counter: shared by CAS/RAS/PRE, width clog2 of max(CAS,RAS,PRE)+1. Loaded on state entry and counts down to 1.

Decomposition:
- Shared package dram_pkg holds:
  - the state enum {IDLE, ACCESS, CAS, RAS, PRE};
  - default timing constants for 7.09 MHz (REFRESH_INTERVAL_7M, TCSR_CYC, TRAS_CYC, TRP_CYC);
  - PENDING_W.
- Natural sub-module: refresh_backlog_counter, containing the timer, the saturating pending counter and the overflow flag. The FSM remains in the top module.

Test Plan:
- Reset, idle bus, 500 cycles:
  - first CAS one cycle after timer tick at cycle 108;
  - RAS high for 2 cycles starting the cycle after CAS;
  - pending returns to 0;
  - a refresh every 108 cycles.
- access_req held for 1000 cycles from reset:
  - pending climbs 1..8 at ticks 108..864;
  - the access stays granted (it is not preempted).
  - Release access_req: 8 back-to-back refreshes of 4 cycles each (CAS, 2×RAS, PRE); pending reaches 0.
- pending=8, access_req pulsed in IDLE:
  - no grant for 4 cycles while one refresh runs;
  - grant on cycle 5;
  - pending=7.
- pending=8 and a further tick during ACCESS → overflow=1, pending stays 8. overflow stays 1 until RESETn low.
- tick coincides with the RAS→PRE done pulse at pending=3 → pending stays 3.
- RESETn low mid-RAS for one cycle → refresh_ras=refresh_cas=0 next cycle, state IDLE, pending=0, timer restarts at 0.
